// File: rtl/bus_sequencer.sv
// bus_sequencer: 16-phase bus interleaver, DMA window in phases 0..7, CPU window in 8..15.
// Define BUS_SEQ_MIRROR_EN to fold CPU accesses at $8xxx onto the configured VRAM size.
module bus_sequencer #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8
) (
  input  logic                        clk_sys_i,
  input  logic                        reset_i,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS-1:0]        req_rw_ni,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]        req_done_o,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic [NUM_PORTS-1:0]        grant_o,
  input  logic [ADDR_W-1:0]           bus_addr_i,
  input  logic [DATA_W-1:0]           bus_data_i,
  input  logic                        bus_rw_ni,
  output logic [ADDR_W-1:0]           bus_addr_o,
  output logic                        bus_addr_oe_o,
  output logic [DATA_W-1:0]           bus_data_o,
  output logic                        bus_data_oe_o,
  output logic                        bus_rw_no,
  output logic [1:0]                  ram_addr_o,
  input  logic                        cfg_80col_i,
  output logic                        ram_oe_no,
  output logic                        ram_we_no,
  output logic                        clk_cpu_o,
  output logic                        cpu_en_o
);

  typedef enum logic [2:0] {
    ARB, ADDR, STROBE, LATCH, RELEASE, CPU
  } st_e;

  logic [3:0]           phase;
  logic [3:0]           nph;
  st_e                  st;
  st_e                  nst;
  logic [1:0]           ptr;
  logic [1:0]           pick;
  logic                 pick_vld;
  logic                 act;
  logic                 rw_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] done;
  logic [DATA_W-1:0]    rd_q;
  logic                 aoe;
  logic                 doe;
  logic                 rwn;
  logic [1:0]           ra;
  logic                 oen;
  logic                 wen;
  logic                 ck;
  logic [3:0]           vld4;
  logic [3:0]           rw4;
  logic [ADDR_W-1:0]    addr_a [4];
  logic [DATA_W-1:0]    data_a [4];
  logic                 go;
  logic                 go_rw;
  logic [1:0]           go_ra;
  logic [1:0]           cpu_ra;
  logic                 unused_in;

  assign nph       = phase + 4'd1;
  assign unused_in = ^{bus_addr_i, cfg_80col_i};

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NUM_PORTS) j = j - NUM_PORTS;
    return j[1:0];
  endfunction

  always_comb begin
    nst = CPU;
    unique case (1'b1)
      nph == 4'd0:                 nst = ARB;
      nph inside {4'd1, 4'd2}:     nst = ADDR;
      nph inside {[4'd3:4'd5]}:    nst = STROBE;
      nph == 4'd6:                 nst = LATCH;
      nph == 4'd7:                 nst = RELEASE;
      nph[3]:                      nst = CPU;
    endcase
  end

  always_comb begin
    vld4 = 4'(req_valid_i);
    rw4  = 4'(req_rw_ni);
    for (int p = 0; p < 4; p++) begin
      addr_a[p] = '0;
      data_a[p] = '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_a[p] = req_addr_i[p*ADDR_W +: ADDR_W];
      data_a[p] = req_data_i[p*DATA_W +: DATA_W];
    end
  end

  // Scan downwards so the port nearest ptr+1 is the last (winning) assignment.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (vld4[rr_idx(ptr, k)]) begin
        pick     = rr_idx(ptr, k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef BUS_SEQ_MIRROR_EN
    if (bus_addr_i[15:12] == 4'h8)
      cpu_ra = cfg_80col_i ? {1'b0, bus_addr_i[10]} : 2'b00;
    else
      cpu_ra = bus_addr_i[11:10];
`else
    cpu_ra = bus_addr_i[11:10];
`endif
  end

  assign go    = (st == ARB) ? pick_vld : act;
  assign go_rw = (st == ARB) ? rw4[pick] : rw_q;
  assign go_ra = (st == ARB) ? addr_a[pick][11:10] : addr_q[11:10];

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      phase  <= '0;
      st     <= ARB;
      ptr    <= 2'(NUM_PORTS - 1);
      act    <= 1'b0;
      rw_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      gnt    <= '0;
      done   <= '0;
      rd_q   <= '0;
      aoe    <= 1'b0;
      doe    <= 1'b0;
      rwn    <= 1'b1;
      ra     <= '0;
      oen    <= 1'b1;
      wen    <= 1'b1;
      ck     <= 1'b0;
    end else begin
      phase <= nph;
      st    <= nst;
      ck    <= nph[3];
      done  <= '0;
      aoe   <= 1'b0;
      doe   <= 1'b0;
      rwn   <= 1'b1;
      oen   <= 1'b1;
      wen   <= 1'b1;
      ra    <= cpu_ra;
      if (st == ARB) begin
        act <= pick_vld;
        gnt <= pick_vld ? (NUM_PORTS'(1) << pick) : '0;
        if (pick_vld) begin
          ptr    <= pick;
          rw_q   <= rw4[pick];
          addr_q <= addr_a[pick];
          data_q <= data_a[pick];
        end
      end
      if (go && !nph[3] && nst != ARB) begin
        aoe <= 1'b1;
        rwn <= go_rw;
        ra  <= go_ra;
      end
      unique case (nst)
        ARB: begin
          act <= 1'b0;
          gnt <= '0;
        end
        ADDR: doe <= go && !go_rw && nph == 4'd2;
        STROBE: begin
          doe <= go && !go_rw;
          wen <= !(go && !go_rw);
          oen <= !(go && go_rw);
        end
        LATCH: begin
          doe <= go && !go_rw;
          oen <= !(go && go_rw);
          if (go) done <= gnt;
        end
        RELEASE: if (go && go_rw) rd_q <= bus_data_i;
        CPU: begin
          oen <= !(bus_rw_ni && nph != 4'd8);
          wen <= !(!bus_rw_ni && nph >= 4'd10 && nph <= 4'd14);
        end
        default: ;
      endcase
    end
  end

  assign req_done_o    = done;
  assign rd_data_o     = rd_q;
  assign grant_o       = gnt;
  assign bus_addr_o    = addr_q;
  assign bus_addr_oe_o = aoe;
  assign bus_data_o    = data_q;
  assign bus_data_oe_o = doe;
  assign bus_rw_no     = rwn;
  assign ram_addr_o    = ra;
  assign ram_oe_no     = oen;
  assign ram_we_no     = wen;
  assign clk_cpu_o     = ck;
  assign cpu_en_o      = ck;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed checks of DMA write/read windows, round-robin,
// CPU window strobes, RAM bank mapping and asynchronous reset abort.
module tb_bus_sequencer;
  localparam int NP = 2;
  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_valid;
  logic [NP-1:0] req_rw_n;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0] req_done;
  logic [DW-1:0] rd_data;
  logic [NP-1:0] grant;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_data_i;
  logic          b_rw_n_i;
  logic [AW-1:0] b_addr_o;
  logic          b_addr_oe;
  logic [DW-1:0] b_data_o;
  logic          b_data_oe;
  logic          b_rw_n_o;
  logic [1:0]    ram_addr;
  logic          cfg_80col;
  logic          ram_oe_n;
  logic          ram_we_n;
  logic          clk_cpu;
  logic          cpu_en;

  int total = 0;
  int bad = 0;
  logic [3:0] ph;

  always #5 clk = ~clk;

  bus_sequencer #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_sys_i     (clk),
    .reset_i       (rst),
    .req_valid_i   (req_valid),
    .req_rw_ni     (req_rw_n),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .req_done_o    (req_done),
    .rd_data_o     (rd_data),
    .grant_o       (grant),
    .bus_addr_i    (b_addr_i),
    .bus_data_i    (b_data_i),
    .bus_rw_ni     (b_rw_n_i),
    .bus_addr_o    (b_addr_o),
    .bus_addr_oe_o (b_addr_oe),
    .bus_data_o    (b_data_o),
    .bus_data_oe_o (b_data_oe),
    .bus_rw_no     (b_rw_n_o),
    .ram_addr_o    (ram_addr),
    .cfg_80col_i   (cfg_80col),
    .ram_oe_no     (ram_oe_n),
    .ram_we_no     (ram_we_n),
    .clk_cpu_o     (clk_cpu),
    .cpu_en_o      (cpu_en)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph = ph + 4'd1;
  endtask

  task automatic go_ph(input logic [3:0] p);
    for (int i = 0; i < 16 && ph != p; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_rw_n = '1;
    req_addr = '0;
    req_data = '0;
    b_addr_i = '0;
    b_data_i = '0;
    b_rw_n_i = 1'b1;
    cfg_80col = 1'b0;
    ph = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_aoe", 32'(b_addr_oe), 0);
    chk("rst_doe", 32'(b_data_oe), 0);
    chk("rst_oe_n", 32'(ram_oe_n), 1);
    chk("rst_we_n", 32'(ram_we_n), 1);
    chk("rst_rw_n", 32'(b_rw_n_o), 1);
    chk("rst_cpuclk", 32'(clk_cpu), 0);
    chk("rst_cpuen", 32'(cpu_en), 0);

    // port 0 write A5 -> 08400
    req_valid = 2'b01;
    req_rw_n = 2'b00;
    req_addr[0 +: AW] = 17'h08400;
    req_data[0 +: DW] = 8'hA5;
    rst = 1'b0;
    ph = 4'd0;
    chk("w_ph0_cpuclk", 32'(clk_cpu), 0);
    tick();
    chk("w_ph1_grant", 32'(grant), 32'h1);
    chk("w_ph1_aoe", 32'(b_addr_oe), 1);
    chk("w_ph1_addr", 32'(b_addr_o), 32'h08400);
    chk("w_ph1_rw", 32'(b_rw_n_o), 0);
    chk("w_ph1_doe", 32'(b_data_oe), 0);
    chk("w_ph1_we", 32'(ram_we_n), 1);
    req_valid = 2'b00;
    req_rw_n = 2'b11;
    req_addr[0 +: AW] = 17'h1FFFF;
    req_data[0 +: DW] = 8'h00;
    tick();
    chk("w_ph2_doe", 32'(b_data_oe), 1);
    chk("w_ph2_data", 32'(b_data_o), 32'hA5);
    chk("w_ph2_we", 32'(ram_we_n), 1);
    chk("w_ph2_addr", 32'(b_addr_o), 32'h08400);
    tick();
    chk("w_ph3_we", 32'(ram_we_n), 0);
    chk("w_ph3_ra", 32'(ram_addr), 32'h1);
    chk("w_ph3_oe", 32'(ram_oe_n), 1);
    go_ph(4'd5);
    chk("w_ph5_we", 32'(ram_we_n), 0);
    chk("w_ph5_done", 32'(req_done), 0);
    tick();
    chk("w_ph6_we", 32'(ram_we_n), 1);
    chk("w_ph6_done", 32'(req_done), 32'h1);
    chk("w_ph6_doe", 32'(b_data_oe), 1);
    tick();
    chk("w_ph7_done", 32'(req_done), 0);
    chk("w_ph7_aoe", 32'(b_addr_oe), 1);
    chk("w_ph7_doe", 32'(b_data_oe), 0);
    chk("w_ph7_rw", 32'(b_rw_n_o), 0);

    // CPU read of $8C00 in this bus cycle
    b_rw_n_i = 1'b1;
    b_addr_i = 17'h08C00;
    tick();
    chk("c_ph8_aoe", 32'(b_addr_oe), 0);
    chk("c_ph8_cpuclk", 32'(clk_cpu), 1);
    chk("c_ph8_cpuen", 32'(cpu_en), 1);
    chk("c_ph8_oe", 32'(ram_oe_n), 1);
    tick();
    chk("c_ph9_oe", 32'(ram_oe_n), 0);
    chk("c_ph9_we", 32'(ram_we_n), 1);
    go_ph(4'd12);
`ifdef BUS_SEQ_MIRROR_EN
    chk("c_8c00_40col", 32'(ram_addr), 32'h0);
`else
    chk("c_8c00_ra", 32'(ram_addr), 32'h3);
`endif
    go_ph(4'd15);
    chk("c_ph15_oe", 32'(ram_oe_n), 0);
    tick();
    chk("c_ph0_oe", 32'(ram_oe_n), 1);
    chk("c_ph0_grant", 32'(grant), 0);
    chk("c_ph0_cpuclk", 32'(clk_cpu), 0);

    // idle DMA window, CPU write window with bank mapping
    b_rw_n_i = 1'b0;
    b_addr_i = 17'h08800;
    cfg_80col = 1'b1;
    tick();
    chk("i_ph1_grant", 32'(grant), 0);
    chk("i_ph1_aoe", 32'(b_addr_oe), 0);
    go_ph(4'd9);
    chk("c_ph9_we_w", 32'(ram_we_n), 1);
    tick();
    chk("c_ph10_we_w", 32'(ram_we_n), 0);
    chk("c_ph10_oe_w", 32'(ram_oe_n), 1);
    go_ph(4'd12);
`ifdef BUS_SEQ_MIRROR_EN
    chk("c_8800_80col", 32'(ram_addr), 32'h0);
`else
    chk("c_8800_ra", 32'(ram_addr), 32'h2);
`endif
    b_addr_i = 17'h08C00;
    go_ph(4'd14);
    chk("c_ph14_we_w", 32'(ram_we_n), 0);
`ifdef BUS_SEQ_MIRROR_EN
    chk("c_8c00_80col", 32'(ram_addr), 32'h1);
`else
    chk("c_8c00_ra2", 32'(ram_addr), 32'h3);
`endif
    b_addr_i = 17'h04C00;
    tick();
    chk("c_ph15_we_w", 32'(ram_we_n), 1);
    chk("c_4c00_ra", 32'(ram_addr), 32'h3);

    // port 1 read, bus data 3C
    tick();
    b_rw_n_i = 1'b1;
    cfg_80col = 1'b0;
    req_valid = 2'b10;
    req_rw_n = 2'b10;
    req_addr[AW +: AW] = 17'h00800;
    b_data_i = 8'h3C;
    tick();
    chk("r_ph1_grant", 32'(grant), 32'h2);
    chk("r_ph1_rw", 32'(b_rw_n_o), 1);
    chk("r_ph1_addr", 32'(b_addr_o), 32'h00800);
    tick();
    chk("r_ph2_doe", 32'(b_data_oe), 0);
    tick();
    chk("r_ph3_oe", 32'(ram_oe_n), 0);
    chk("r_ph3_we", 32'(ram_we_n), 1);
    chk("r_ph3_ra", 32'(ram_addr), 32'h2);
    go_ph(4'd6);
    chk("r_ph6_oe", 32'(ram_oe_n), 0);
    chk("r_ph6_done", 32'(req_done), 32'h2);
    chk("r_ph6_rd", 32'(rd_data), 0);
    tick();
    chk("r_ph7_rd", 32'(rd_data), 32'h3C);
    chk("r_ph7_oe", 32'(ram_oe_n), 1);
    chk("r_ph7_done", 32'(req_done), 0);
    req_valid = 2'b00;
    b_data_i = 8'h55;
    tick();
    chk("r_ph8_rd_hold", 32'(rd_data), 32'h3C);

    // both ports continuously: 0,1,0,1
    go_ph(4'd0);
    req_valid = 2'b11;
    req_rw_n = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rr_grant%0d", c), 32'(grant), (c % 2 == 0) ? 32'h1 : 32'h2);
      go_ph(4'd6);
      chk($sformatf("rr_done%0d", c), 32'(req_done), (c % 2 == 0) ? 32'h1 : 32'h2);
      go_ph(4'd0);
    end

    // reset in the middle of a port 0 write
    req_valid = 2'b01;
    req_rw_n = 2'b00;
    req_data[0 +: DW] = 8'h77;
    tick();
    chk("a_ph1_grant", 32'(grant), 32'h1);
    go_ph(4'd4);
    chk("a_ph4_we", 32'(ram_we_n), 0);
    rst = 1'b1;
    #1;
    chk("a_rst_we", 32'(ram_we_n), 1);
    chk("a_rst_aoe", 32'(b_addr_oe), 0);
    chk("a_rst_grant", 32'(grant), 0);
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_done", 32'(req_done), 0);
    rst = 1'b0;
    ph = 4'd0;
    chk("a_ph0_grant", 32'(grant), 0);
    tick();
    chk("a_ph1_idle", 32'(grant), 0);
    chk("a_ph1_done", 32'(req_done), 0);

    // pointer restarts so port 0 wins
    go_ph(4'd0);
    req_valid = 2'b11;
    req_rw_n = 2'b11;
    tick();
    chk("p_ptr_grant", 32'(grant), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
